// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Writeback stage of the 5-stage RISC-V core. Selects the writeback value
//   from the MEM/WB bundle, commits it into the architectural register file,
//   serves the two decode read ports with same-cycle write-through bypass,
//   and keeps a wrapping count of committed register writes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   alu_result_w_i    ALU result from MEM/WB
//   read_data_w_i     load data from MEM/WB
//   pc_plus4_w_i      PC+4 from MEM/WB
//   rd_w_i            destination register index
//   result_src_w_i    result select (00 alu, 01 load, 10 pc+4, 11 zero)
//   reg_write_w_i     register write enable
//   rs1_d_i, rs2_d_i  decode read indices
//   rd1_d_o, rd2_d_o  decode read data
//   result_w_o        selected writeback value (to hazard-unit forwarding)
//   write_count_o     committed-write counter, wraps at 2^32

module writeback_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     alu_result_w_i,
    input  logic [DATA_WIDTH-1:0]     read_data_w_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_w_i,
    input  logic [REGISTER_WIDTH-1:0] rd_w_i,
    input  logic [1:0]                result_src_w_i,
    input  logic                      reg_write_w_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
    output logic [DATA_WIDTH-1:0]     rd1_d_o,
    output logic [DATA_WIDTH-1:0]     rd2_d_o,
    output logic [DATA_WIDTH-1:0]     result_w_o,
    output logic [31:0]               write_count_o
);

    localparam int DEPTH = 1 << REGISTER_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [31:0]           write_count_q;
    logic [31:0]           write_count_d;
    logic                  commit;

    always_comb begin
        result_w_o = '0;
        case (result_src_w_i)
            2'b00:   result_w_o = alu_result_w_i;
            2'b01:   result_w_o = read_data_w_i;
            2'b10:   result_w_o = pc_plus4_w_i;
            default: result_w_o = '0;
        endcase
    end

    // Writes to x0 are architecturally meaningless, so they never commit.
    assign commit = reg_write_w_i && (rd_w_i != '0);

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (commit) begin
            regs_d[rd_w_i] = result_w_o;
            write_count_d  = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // Reads are forced to zero during reset so decode never sees stale
    // contents or a bypassed value from a commit that is about to be dropped.
    always_comb begin
        rd1_d_o = '0;
        if (!rst && (rs1_d_i != '0)) begin
            if (commit && (rs1_d_i == rd_w_i)) begin
                rd1_d_o = result_w_o;
            end else begin
                rd1_d_o = regs_q[rs1_d_i];
            end
        end
    end

    always_comb begin
        rd2_d_o = '0;
        if (!rst && (rs2_d_i != '0)) begin
            if (commit && (rs2_d_i == rd_w_i)) begin
                rd2_d_o = result_w_o;
            end else begin
                rd2_d_o = regs_q[rs2_d_i];
            end
        end
    end

    assign write_count_o = write_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result_w_i;
    logic [31:0] read_data_w_i;
    logic [31:0] pc_plus4_w_i;
    logic [4:0]  rd_w_i;
    logic [1:0]  result_src_w_i;
    logic        reg_write_w_i;
    logic [4:0]  rs1_d_i;
    logic [4:0]  rs2_d_i;
    logic [31:0] rd1_d_o;
    logic [31:0] rd2_d_o;
    logic [31:0] result_w_o;
    logic [31:0] write_count_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;

    writeback_regfile #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_result_w_i (alu_result_w_i),
        .read_data_w_i  (read_data_w_i),
        .pc_plus4_w_i   (pc_plus4_w_i),
        .rd_w_i         (rd_w_i),
        .result_src_w_i (result_src_w_i),
        .reg_write_w_i  (reg_write_w_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rd1_d_o        (rd1_d_o),
        .rd2_d_o        (rd2_d_o),
        .result_w_o     (result_w_o),
        .write_count_o  (write_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] alu,
                                               input logic [31:0] ld, input logic [31:0] pc);
        logic [31:0] r;
        if (src == 2'd0)      r = alu;
        else if (src == 2'd1) r = ld;
        else if (src == 2'd2) r = pc;
        else                  r = 32'd0;
        return r;
    endfunction

    // Reference read: x0 and reset read zero, a same-cycle commit to the
    // requested register is visible immediately, otherwise the stored value.
    function automatic logic [31:0] ref_read(input logic [4:0] rs, input logic r, input logic cm,
                                             input logic [4:0] rd, input logic [31:0] res);
        if (r || rs == 5'd0) return 32'd0;
        if (cm && rs == rd)  return res;
        return m_rf[rs];
    endfunction

    // One full cycle: drive just after a falling edge, check combinational
    // outputs, step the model on the rising edge, check the counter afterwards.
    task automatic run_cycle(input logic r, input logic we, input logic [4:0] rd,
                             input logic [1:0] src, input logic [31:0] alu,
                             input logic [31:0] ld, input logic [31:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] er;
        logic        cm;
        rst = r; reg_write_w_i = we; rd_w_i = rd; result_src_w_i = src;
        alu_result_w_i = alu; read_data_w_i = ld; pc_plus4_w_i = pc;
        rs1_d_i = rs1; rs2_d_i = rs2;
        #1;
        er = ref_result(src, alu, ld, pc);
        cm = we && (rd != 5'd0);
        chk("result_w", result_w_o, er);
        chk("rd1", rd1_d_o, ref_read(rs1, r, cm, rd, er));
        chk("rd2", rd2_d_o, ref_read(rs2, r, cm, rd, er));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (cm) begin
            m_rf[rd] = er;
            m_cnt    = m_cnt + 32'd1;
        end
        @(negedge clk);
        chk("write_count", write_count_o, m_cnt);
    endtask

    task automatic idle_read(input logic [4:0] rs1, input logic [4:0] rs2);
        run_cycle(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, rs1, rs2);
    endtask

    initial begin
        logic [4:0]  rd;
        logic [4:0]  a;
        logic [4:0]  b;
        logic        r;
        m_cnt = 32'd0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        rst = 1'b1; reg_write_w_i = 1'b0; rd_w_i = '0; result_src_w_i = '0;
        alu_result_w_i = '0; read_data_w_i = '0; pc_plus4_w_i = '0;
        rs1_d_i = '0; rs2_d_i = '0;
        @(negedge clk);

        // Initial reset, then preload x5 and reset again.
        run_cycle(1'b1, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        run_cycle(1'b0, 1'b1, 5'd5, 2'd0, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0);
        idle_read(5'd5, 5'd0);
        chk("preload_x5", rd1_d_o, 32'h1234);
        run_cycle(1'b1, 1'b1, 5'd6, 2'd0, 32'h77, 32'd0, 32'd0, 5'd5, 5'd6);
        idle_read(5'd5, 5'd6);
        chk("x5_after_reset", rd1_d_o, 32'd0);
        chk("count_after_reset", write_count_o, 32'd0);

        // Result mux and commit, each value read back the following cycle.
        run_cycle(1'b0, 1'b1, 5'd3, 2'd0, 32'hDEADBEEF, 32'h1, 32'h2, 5'd0, 5'd0);
        run_cycle(1'b0, 1'b1, 5'd4, 2'd1, 32'h3, 32'h0000_00FF, 32'h4, 5'd3, 5'd0);
        chk("x3", rd1_d_o, 32'hDEADBEEF);
        run_cycle(1'b0, 1'b1, 5'd5, 2'd2, 32'h5, 32'h6, 32'h104, 5'd4, 5'd3);
        chk("x4", rd1_d_o, 32'hFF);
        idle_read(5'd5, 5'd4);
        chk("x5", rd1_d_o, 32'h104);
        chk("count_three", write_count_o, 32'd3);

        // x0 protection.
        run_cycle(1'b0, 1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0);
        chk("x0_read", rd1_d_o, 32'd0);
        chk("x0_count", write_count_o, 32'd3);

        // Same-cycle bypass on both ports.
        run_cycle(1'b0, 1'b1, 5'd7, 2'd0, 32'hCAFE, 32'd0, 32'd0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);
        chk("x7_stored", rd2_d_o, 32'hCAFE);

        // Bubble: no write, no bypass.
        run_cycle(1'b0, 1'b0, 5'd8, 2'd0, 32'h55, 32'd0, 32'd0, 5'd8, 5'd8);
        idle_read(5'd8, 5'd0);
        chk("x8_bubble", rd1_d_o, 32'd0);

        // Counter wrap with the zero source; x9 holds a nonzero value first.
        run_cycle(1'b0, 1'b1, 5'd9, 2'd0, 32'hABCD, 32'd0, 32'd0, 5'd0, 5'd0);
        force dut.write_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.write_count_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("count_forced", write_count_o, 32'hFFFF_FFFF);
        run_cycle(1'b0, 1'b1, 5'd9, 2'd3, 32'h11, 32'h22, 32'h33, 5'd9, 5'd0);
        chk("count_wrapped", write_count_o, 32'd0);
        idle_read(5'd9, 5'd9);
        chk("x9_zero", rd1_d_o, 32'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            r  = ($urandom_range(0, 59) == 0);
            run_cycle(r, 1'($urandom_range(0, 1)), rd, 2'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
